// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage: colour bars, scrolling checker, solid fill or ramp,
// selected frame-synchronously, with every output registered one clock after its inputs.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CNT_W      = 10,
  parameter int R_W        = 5,
  parameter int G_W        = 6,
  parameter int B_W        = 5,
  parameter int NUM_BARS   = 8,
  parameter int BAR_W      = 80,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         hcount,
  input  logic [CNT_W-1:0]         vcount,
  input  logic                     hblank,
  input  logic                     vblank,
  input  logic [1:0]               mode_in,
  input  logic                     mode_load,
  input  logic [R_W+G_W+B_W-1:0]   solid_rgb,
  output logic [R_W-1:0]           red,
  output logic [G_W-1:0]           green,
  output logic [B_W-1:0]           blue,
  output logic                     pix_valid,
  output logic [1:0]               mode_active,
  output logic [7:0]               frame_cnt
);

  localparam int RGB_W = R_W + G_W + B_W;
  localparam logic [CNT_W:0]   H_LIM    = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   V_LIM    = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_BARS - 1);

  logic [R_W-1:0]   red_q, red_d;
  logic [G_W-1:0]   green_q, green_d;
  logic [B_W-1:0]   blue_q, blue_d;
  logic             pix_valid_q, pix_valid_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       frame_q, frame_d;
  logic [CNT_W-1:0] bar_pos_q, bar_pos_d;
  logic [CNT_W-1:0] bar_idx_q, bar_idx_d;
  logic             vblank_q;

  logic             blank_in;
  logic             vrise;
  logic [2:0]       bar_sel;
  logic [CNT_W-1:0] hs;

  always_comb begin
    blank_in = hblank | vblank | ({1'b0, hcount} >= H_LIM) | ({1'b0, vcount} >= V_LIM);
    vrise    = vblank & ~vblank_q;

    // A strobe coinciding with the vblank rise lands in mode_active on the same edge,
    // because the frame-boundary load takes the already-updated pending value.
    pending_d = mode_load ? mode_in : pending_q;
    mode_d    = mode_q;
    frame_d   = frame_q;
    if (vrise) begin
      mode_d  = pending_d;
      frame_d = frame_q + 8'd1;
    end

    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    if (hblank) begin
      bar_pos_d = '0;
      bar_idx_d = '0;
    end else if (!blank_in) begin
      if (bar_pos_q == BAR_LAST) begin
        bar_pos_d = '0;
        if (bar_idx_q != IDX_LAST) bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_pos_d = bar_pos_q + 1'b1;
      end
    end

    bar_sel = bar_idx_q[2:0];
    hs      = hcount + CNT_W'(frame_q);

    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    pix_valid_d = 1'b0;
    if (!blank_in) begin
      pix_valid_d = 1'b1;
      case (mode_q)
        2'd0: begin
          red_d   = {R_W{~bar_sel[1]}};
          green_d = {G_W{~bar_sel[2]}};
          blue_d  = {B_W{~bar_sel[0]}};
        end
        2'd1: begin
          red_d   = {R_W{hs[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
          green_d = {G_W{hs[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
          blue_d  = {B_W{hs[CHECK_LOG2] ^ vcount[CHECK_LOG2]}};
        end
        2'd2: begin
          red_d   = solid_rgb[RGB_W-1 -: R_W];
          green_d = solid_rgb[G_W+B_W-1 -: G_W];
          blue_d  = solid_rgb[B_W-1:0];
        end
        default: begin
          red_d   = hcount[R_W+1:2];
          green_d = hcount[G_W+1:2];
          blue_d  = hcount[B_W+1:2];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      pix_valid_q <= 1'b0;
      pending_q   <= 2'd0;
      mode_q      <= 2'd0;
      frame_q     <= 8'd0;
      bar_pos_q   <= '0;
      bar_idx_q   <= '0;
      vblank_q    <= 1'b0;
    end else begin
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      pix_valid_q <= pix_valid_d;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      frame_q     <= frame_d;
      bar_pos_q   <= bar_pos_d;
      bar_idx_q   <= bar_idx_d;
      vblank_q    <= vblank;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign pix_valid   = pix_valid_q;
  assign mode_active = mode_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed scenarios plus random traffic, all outputs
// compared against an arithmetic pixel model one clock after the inputs are driven.
module tb_vga_pattern_gen;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BAR_W    = 80;
  localparam int NUM_BARS = 8;
  localparam int CHECK_SZ = 32;
  localparam int H_WRAP   = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hblank = 1'b1;
  logic        vblank = 1'b0;
  logic [1:0]  mode_in = '0;
  logic        mode_load = 1'b0;
  logic [15:0] solid_rgb = '0;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        pix_valid;
  logic [1:0]  mode_active;
  logic [7:0]  frame_cnt;

  logic [26:0] got_all;
  logic [26:0] exp_all;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Model state: requested/displayed mode, frame count, previous vblank and the
  // number of active pixels since the last hblank (which decides the colour bar).
  int m_pending, m_active, m_frame, m_vbd, m_n;

  assign got_all = {red, green, blue, pix_valid, mode_active, frame_cnt};

  vga_pattern_gen dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hblank(hblank), .vblank(vblank), .mode_in(mode_in), .mode_load(mode_load),
    .solid_rgb(solid_rgb), .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .mode_active(mode_active), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bar_colour(input int idx);
    case (idx % 8)
      0: return {5'd31, 6'd63, 5'd31};
      1: return {5'd31, 6'd63, 5'd0};
      2: return {5'd0,  6'd63, 5'd31};
      3: return {5'd0,  6'd63, 5'd0};
      4: return {5'd31, 6'd0,  5'd31};
      5: return {5'd31, 6'd0,  5'd0};
      6: return {5'd0,  6'd0,  5'd31};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] model_pixel(input int h, input int v);
    int bar;
    int hs;
    logic [4:0] r5;
    logic [5:0] g6;
    case (m_active)
      0: begin
        bar = m_n / BAR_W;
        if (bar > NUM_BARS - 1) bar = NUM_BARS - 1;
        return bar_colour(bar);
      end
      1: begin
        hs = (h + m_frame) % H_WRAP;
        return ((((hs / CHECK_SZ) ^ (v / CHECK_SZ)) % 2) == 1) ? 16'hFFFF : 16'h0000;
      end
      2: return solid_rgb;
      default: begin
        r5 = 5'((h / 4) % 32);
        g6 = 6'((h / 4) % 64);
        return {r5, g6, r5};
      end
    endcase
  endfunction

  // Drives one cycle, predicts the outputs that appear after the edge, and returns
  // with the DUT outputs settled (1 time unit after the edge).
  task automatic step(input int h, input int v, input bit hb, input bit vb,
                      input bit ml, input int mi, input bit r);
    bit blank;
    logic [15:0] rgb;
    hcount    = h[9:0];
    vcount    = v[9:0];
    hblank    = hb;
    vblank    = vb;
    mode_load = ml;
    mode_in   = mi[1:0];
    rst       = r;
    blank = hb || vb || (h >= H_ACTIVE) || (v >= V_ACTIVE);
    rgb   = blank ? 16'h0000 : model_pixel(h, v);
    if (r) begin
      rgb = 16'h0000;
      blank = 1'b1;
      m_pending = 0; m_active = 0; m_frame = 0; m_vbd = 0; m_n = 0;
    end else begin
      if (ml) m_pending = mi;
      if (vb && !m_vbd) begin
        m_frame  = (m_frame + 1) % 256;
        m_active = ml ? mi : m_pending;
      end
      m_vbd = vb;
      if (hb) m_n = 0;
      else if (!blank) m_n++;
    end
    exp_all = {rgb, !blank, 2'(m_active), 8'(m_frame)};
    @(posedge clk);
    #1;
  endtask

  task automatic vrise_pair(input bit ml2, input int mi2);
    step(0, V_ACTIVE, 1, 0, 0, 0, 0);
    step(0, V_ACTIVE, 1, 1, ml2, mi2, 0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    n_tests++;
    if (got_all !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h exp %h", got_all, 27'd0);
    end
  endtask

  task automatic test_bars;
    step(0, 0, 1, 0, 0, 0, 0);
    for (int h = 0; h < H_ACTIVE; h++) begin
      step(h, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (got_all !== exp_all) begin
        n_fail++;
        $display("FAIL bars h=%0d: got %h exp %h", h, got_all, exp_all);
      end
      if (h == 0 || h == 80 || h == 600) begin
        n_tests++;
        if ({red, green, blue} !== (h == 0 ? {5'd31, 6'd63, 5'd31} :
                                    h == 80 ? {5'd31, 6'd63, 5'd0} : 16'h0000)) begin
          n_fail++;
          $display("FAIL bar_const h=%0d: got %h", h, {red, green, blue});
        end
      end
    end
  endtask

  task automatic test_mode_change;
    solid_rgb = {5'd3, 6'd40, 5'd17};
    step(0, 10, 1, 0, 0, 0, 0);
    for (int h = 0; h < 20; h++) begin
      step(h, 10, 0, 0, (h == 5), 2, 0);
      n_tests++;
      if (mode_active !== 2'd0 || got_all !== exp_all) begin
        n_fail++;
        $display("FAIL mode_hold h=%0d: got %h exp %h", h, got_all, exp_all);
      end
    end
    vrise_pair(0, 0);
    n_tests++;
    if (mode_active !== 2'd2) begin
      n_fail++;
      $display("FAIL mode_switch: got %0d exp 2", mode_active);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({red, green, blue, pix_valid} !== {5'd3, 6'd40, 5'd17, 1'b1}) begin
      n_fail++;
      $display("FAIL solid_pixel: got %h exp %h", {red, green, blue, pix_valid},
               {5'd3, 6'd40, 5'd17, 1'b1});
    end
  endtask

  task automatic test_same_edge_load;
    vrise_pair(1, 3);
    n_tests++;
    if (mode_active !== 2'd3) begin
      n_fail++;
      $display("FAIL same_edge_mode: got %0d exp 3", mode_active);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    for (int h = 0; h <= 12; h++) step(h, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({red, green, blue} !== {5'd3, 6'd3, 5'd3} || got_all !== exp_all) begin
      n_fail++;
      $display("FAIL ramp_h12: got %h exp %h", got_all, exp_all);
    end
  endtask

  task automatic test_frame_wrap;
    int start;
    bit saw_wrap;
    start = m_frame;
    saw_wrap = 0;
    for (int i = 0; i < 256; i++) begin
      vrise_pair(0, 0);
      if (m_frame == 0) begin
        saw_wrap = 1;
        n_tests++;
        if (frame_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL frame_wrap_zero: got %0d exp 0", frame_cnt);
        end
      end
    end
    n_tests++;
    if (!saw_wrap || frame_cnt !== 8'(start) || got_all !== exp_all) begin
      n_fail++;
      $display("FAIL frame_wrap_256: got %h exp %h", got_all, exp_all);
    end
  endtask

  task automatic test_checker;
    int guard;
    step(0, 5, 1, 0, 0, 0, 0);
    step(1, 5, 0, 0, 1, 2, 0);
    step(2, 5, 0, 0, 1, 0, 0);
    step(3, 5, 0, 0, 1, 1, 0);
    guard = 0;
    do begin
      vrise_pair(0, 0);
      guard++;
    end while (m_frame != 0 && guard < 300);
    n_tests++;
    if (mode_active !== 2'd1 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL checker_setup: got mode %0d frame %0d exp 1 0", mode_active, frame_cnt);
    end
    step(0, 0, 1, 0, 0, 0, 0);
    for (int h = 0; h < 64; h++) begin
      step(h, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (got_all !== exp_all ||
          (h == 0 && {red, green, blue} !== 16'h0000) ||
          (h == 32 && {red, green, blue} !== 16'hFFFF)) begin
        n_fail++;
        $display("FAIL checker_f0 h=%0d: got %h exp %h", h, got_all, exp_all);
      end
    end
    for (int i = 0; i < 10; i++) vrise_pair(0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int h = 0; h <= 22; h++) step(h, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({red, green, blue} !== 16'hFFFF || frame_cnt !== 8'd10) begin
      n_fail++;
      $display("FAIL checker_f10_h22: got %h frame %0d exp ffff 10", {red, green, blue}, frame_cnt);
    end
  endtask

  task automatic test_reset_midline;
    step(0, 40, 1, 0, 1, 0, 0);
    vrise_pair(0, 0);
    step(0, 41, 1, 0, 0, 0, 0);
    for (int h = 0; h < H_ACTIVE; h++) begin
      step(h, 41, 0, 0, (h == 300), 3, (h == 300));
      n_tests++;
      if (got_all !== exp_all || (h == 300 && got_all !== 27'd0)) begin
        n_fail++;
        $display("FAIL reset_midline h=%0d: got %h exp %h", h, got_all, exp_all);
      end
    end
    step(0, 42, 1, 0, 0, 0, 0);
    for (int h = 0; h < 100; h++) begin
      step(h, 42, 0, 0, 0, 0, 0);
      n_tests++;
      if (got_all !== exp_all || (h == 0 && {red, green, blue} !== 16'hFFFF)) begin
        n_fail++;
        $display("FAIL after_reset_line h=%0d: got %h exp %h", h, got_all, exp_all);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) solid_rgb = 16'($urandom);
      step($urandom_range(0, 700), $urandom_range(0, 520),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 299) == 0));
      n_tests++;
      if (got_all !== exp_all) begin
        n_fail++;
        $display("FAIL random i=%0d: got %h exp %h", i, got_all, exp_all);
      end
    end
  endtask

  initial begin
    m_pending = 0; m_active = 0; m_frame = 0; m_vbd = 0; m_n = 0;
    test_reset;
    test_bars;
    test_mode_change;
    test_same_edge_load;
    test_frame_wrap;
    test_checker;
    test_reset_midline;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
